pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 4, multiply latency in cycles (range 1..255).
REQ-002 Parameter DIV_CYCLES, default 32, divide latency in cycles (range 1..255).
REQ-003 clk  in  1  global clock; all state updates on posedge.
REQ-004 clr  in  1  asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 id_hilo_use  in  1  ID instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo).
REQ-008 id_mdu_op  in  1  ID instruction is mult/multu/div/divu.
REQ-009 ex_write_num  in  5  destination register of the instruction in EX.
REQ-010 ex_mem_read  in  1  EX instruction is a load.
REQ-011 ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-012 ex_mdu_start  in  1  EX instruction issues to the multiply/divide unit.
REQ-013 ex_mdu_div  in  1  qualifies ex_mdu_start: 1 = divide, 0 = multiply.
REQ-014 ex_syscall  in  1  EX instruction is syscall.
REQ-015 ex_v0  in  32  forwarded $v0 value seen by EX.
REQ-016 pc_en  out  1  PC register update enable.
REQ-017 ifid_en  out  1  IF/ID latch enable.
REQ-018 ifid_clr  out  1  IF/ID latch flush, loads NOP.
REQ-019 idex_clr  out  1  drives the ID/EX latch clear, inserts bubble.
REQ-020 mdu_busy  out  1  multiply/divide unit occupied.
REQ-021 halted  out  1  processor stopped by exit syscall.
REQ-022 stall_count  out  32  performance counter of stall cycles.

Function
REQ-023 The block SHALL have states RUN, BUSY, HALT.
REQ-024 load_use SHALL be ex_mem_read AND ex_write_num != 0 AND ((id_use_rs AND id_rs == ex_write_num) OR (id_use_rt AND id_rt == ex_write_num)).
REQ-025 mdu_hazard SHALL be (state == BUSY) AND (id_hilo_use OR id_mdu_op).
REQ-026 Output priority SHALL be HALT > ex_branch_taken > (load_use OR mdu_hazard) > normal; all outputs are combinational from state and inputs.
REQ-027 HALT: pc_en=0, ifid_en=0, ifid_clr=0, idex_clr=1, halted=1.
REQ-028 Taken branch: pc_en=1, ifid_en=1, ifid_clr=1, idex_clr=1, with hazards ignored that cycle.
REQ-029 Stall: pc_en=0, ifid_en=0, ifid_clr=0, idex_clr=1.
REQ-030 Normal: pc_en=1, ifid_en=1, ifid_clr=0, idex_clr=0.
REQ-031 ex_syscall AND ex_v0 == 32'd10 in RUN or BUSY SHALL enter HALT next cycle; HALT exits only on clr.
REQ-032 ex_mdu_start in RUN, with no halt condition, SHALL load the 8-bit counter with (ex_mdu_div ? DIV_CYCLES : MULT_CYCLES) - 1 and enter BUSY.
REQ-033 In BUSY, the counter SHALL decrement each cycle; BUSY with counter == 0 SHALL return to RUN next cycle.
REQ-034 ex_mdu_start SHALL be accepted when coincident with ex_branch_taken.
REQ-035 ex_mdu_start in BUSY SHALL be ignored, since ID stalls prevent it.
REQ-036 mdu_busy SHALL be 1 exactly while state == BUSY.
REQ-037 stall_count SHALL increment on each cycle with pc_en == 0 and state != HALT, saturating at 32'hFFFFFFFF.

Reset
REQ-038 While clr=1, regardless of clk: state=RUN, counter=0, stall_count=0, halted=0, mdu_busy=0.
REQ-039 While clr=1, outputs SHALL follow REQ-026..030 for state RUN.
REQ-040 clr asserted mid-BUSY or in HALT SHALL abort immediately with no residual stall.

Verification
REQ-041 EX lw ex_write_num=8, ex_mem_read=1; ID id_rs=8, id_use_rs=1 -> one cycle pc_en=0, ifid_en=0, idex_clr=1; stall_count 0->1.
REQ-042 Same as REQ-041 with ex_write_num=0 -> no stall; pc_en=1, idex_clr=0.
REQ-043 ex_mdu_start=1, ex_mdu_div=0, then id_hilo_use=1 held -> mdu_busy=1 for 4 cycles, stall for those 4 cycles, RUN on 5th; with ex_mdu_div=1 -> 32 busy cycles.
REQ-044 ex_branch_taken=1 concurrent with load_use -> ifid_clr=1, idex_clr=1, pc_en=1; stall_count unchanged.
REQ-045 ex_syscall=1, ex_v0=10 -> next cycle halted=1, pc_en=0; stays halted 100 cycles; ex_v0=1 -> no halt.
REQ-046 clr pulse, not clock-aligned, during BUSY counter=20 -> mdu_busy=0 and stall_count=0 before the next posedge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: load-use and
// multiply/divide interlocks, branch flushes, exit-syscall halt, stall counter.
module pipeline_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_hilo_use,
    input  logic        id_mdu_op,
    input  logic [4:0]  ex_write_num,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_mdu_start,
    input  logic        ex_mdu_div,
    input  logic        ex_syscall,
    input  logic [31:0] ex_v0,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        mdu_busy,
    output logic        halted,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {RUN, BUSY, HALT} state_t;

    // The counter holds remaining busy cycles minus one, so BUSY at zero is the last one.
    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] count;
    logic [7:0] count_nxt;
    logic       load_use;
    logic       mdu_hazard;
    logic       halt_req;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        load_use   = ex_mem_read && (ex_write_num != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_write_num)) ||
                      (id_use_rt && (id_rt == ex_write_num)));
        mdu_hazard = (state == BUSY) && (id_hilo_use || id_mdu_op);
        halt_req   = ex_syscall && (ex_v0 == 32'd10);
    end

    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;
        halted   = (state == HALT);
        mdu_busy = (state == BUSY);
        if (state == HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (load_use || mdu_hazard) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else if (ex_mdu_start) begin
                    state_nxt = BUSY;
                    count_nxt = ex_mdu_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (halt_req) begin
                    state_nxt = HALT;
                    count_nxt = 8'd0;
                end else if (count == 8'd0) begin
                    state_nxt = RUN;
                end else begin
                    count_nxt = count - 8'd1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
                count_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= RUN;
            count <= 8'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_count <= 32'd0;
        end else if (!pc_en && (state != HALT)) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule
